// File: rtl/adc_capture_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | adc_capture_sequencer: trigger arbitration, start delay and capture-length  |
// | sequencing for the ADC raw-capture FIFO path. Option: ADC_SEQ_DROP_CNT_EN.  |
// | GPIO bus: [31] w_clk, [15:8] addr, [7:0] data.        Revision: 1.0         |
// +----------------------------------------------------------------------------+
module adc_capture_sequencer #(
  parameter int BASE_ADDR = 5,
  parameter int LEN_W     = 10,
  parameter int DLY_W     = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] gpio_in,
  input  logic        cpu_trig,
  input  logic        fsm_run,
  input  logic        fifo_tready,
  output logic        cap_valid,
  output logic        busy,
  output logic        done,
  output logic        grant_fsm,
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam logic [7:0] ADDR_DLY_LO = 8'(BASE_ADDR);
  localparam logic [7:0] ADDR_DLY_HI = 8'(BASE_ADDR + 1);
  localparam logic [7:0] ADDR_LEN_LO = 8'(BASE_ADDR + 2);
  localparam logic [7:0] ADDR_LEN_HI = 8'(BASE_ADDR + 3);
  localparam logic [7:0] ADDR_CTRL   = 8'(BASE_ADDR + 4);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DELAY   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3
  } state_e;

  logic [2:0]       wclk_sync_q;
  logic             wr_stb;
  logic [7:0]       wr_addr;
  logic [7:0]       wr_data;
  logic             unused_gpio;
  logic [DLY_W-1:0] dly_q;
  logic [LEN_W-1:0] len_q;
  logic [1:0]       ctrl_q;
  logic [15:0]      dly_ext;
  logic [15:0]      len_ext;

  assign wr_stb      = wclk_sync_q[1] & ~wclk_sync_q[2];
  assign wr_addr     = gpio_in[15:8];
  assign wr_data     = gpio_in[7:0];
  assign unused_gpio = ^gpio_in[30:16];
  assign dly_ext     = 16'(dly_q);
  assign len_ext     = 16'(len_q);

  // Two flops synchronise w_clk; the third gives the rising-edge reference.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) wclk_sync_q <= '0;
    else      wclk_sync_q <= {wclk_sync_q[1:0], gpio_in[31]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dly_q  <= '0;
      len_q  <= '1;
      ctrl_q <= 2'b11;
    end else if (wr_stb) begin
      case (wr_addr)
        ADDR_DLY_LO: dly_q  <= DLY_W'({dly_ext[15:8], wr_data});
        ADDR_DLY_HI: dly_q  <= DLY_W'({wr_data, dly_ext[7:0]});
        ADDR_LEN_LO: len_q  <= LEN_W'({len_ext[15:8], wr_data});
        ADDR_LEN_HI: len_q  <= LEN_W'({wr_data, len_ext[7:0]});
        ADDR_CTRL:   ctrl_q <= wr_data[1:0];
        default:     ;
      endcase
    end
  end

  logic cpu_s_q, cpu_q, fsm_s_q, fsm_q;
  logic cpu_edge, fsm_edge, start_d, hold_rel_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cpu_s_q <= 1'b0;
      cpu_q   <= 1'b0;
      fsm_s_q <= 1'b0;
      fsm_q   <= 1'b0;
    end else begin
      cpu_s_q <= cpu_trig;
      cpu_q   <= cpu_s_q;
      fsm_s_q <= fsm_run;
      fsm_q   <= fsm_s_q;
    end
  end

  state_e           state_q;
  logic [DLY_W-1:0] dcnt_q;
  logic [LEN_W-1:0] lcnt_q;
  logic             cap_valid_q, busy_q, done_q, grant_q, ovf_q;

  assign cpu_edge   = cpu_s_q & ~cpu_q & ctrl_q[0];
  assign fsm_edge   = fsm_s_q & ~fsm_q & ctrl_q[1];
  assign start_d    = (state_q == S_IDLE) & (cpu_edge | fsm_edge);
  assign hold_rel_d = grant_q ? ~fsm_s_q : ~cpu_s_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      dcnt_q      <= '0;
      lcnt_q      <= '0;
      cap_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      grant_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_d) begin
            grant_q <= fsm_edge;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b1;
            dcnt_q  <= dly_q;
            lcnt_q  <= len_q;
            if (dly_q == '0) begin
              state_q     <= S_CAPTURE;
              cap_valid_q <= 1'b1;
            end else begin
              state_q <= S_DELAY;
            end
          end
        end
        S_DELAY: begin
          if (dcnt_q == DLY_W'(1)) begin
            state_q     <= S_CAPTURE;
            cap_valid_q <= 1'b1;
          end else begin
            dcnt_q <= dcnt_q - DLY_W'(1);
          end
        end
        S_CAPTURE: begin
          // The ADC stream never stalls; a refused word is simply lost.
          if (!fifo_tready) ovf_q <= 1'b1;
          if (lcnt_q == '0) begin
            state_q     <= S_HOLD;
            cap_valid_q <= 1'b0;
            done_q      <= 1'b1;
          end else begin
            lcnt_q <= lcnt_q - LEN_W'(1);
          end
        end
        S_HOLD: begin
          if (hold_rel_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cap_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign cap_valid = cap_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign grant_fsm = grant_q;
  assign overflow  = ovf_q;

`ifdef ADC_SEQ_DROP_CNT_EN
  logic [15:0] drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_q <= '0;
    end else if (start_d) begin
      drop_q <= '0;
    end else if (state_q == S_CAPTURE && !fifo_tready && drop_q != 16'hFFFF) begin
      drop_q <= drop_q + 16'd1;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_capture_sequencer.sv
`default_nettype none
// Bench for adc_capture_sequencer: directed scenarios plus randomized captures
// checked against a window/count model of the capture timing rules.
module tb_adc_capture_sequencer;

  localparam int BASE = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] gpio_in = '0;
  logic        cpu_trig = 1'b0;
  logic        fsm_run = 1'b0;
  logic        fifo_tready = 1'b1;
  logic        cap_valid, busy, done, grant_fsm, overflow;
  logic [15:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  adc_capture_sequencer dut (
    .clk(clk), .rst(rst), .gpio_in(gpio_in), .cpu_trig(cpu_trig),
    .fsm_run(fsm_run), .fifo_tready(fifo_tready), .cap_valid(cap_valid),
    .busy(busy), .done(done), .grant_fsm(grant_fsm), .overflow(overflow),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int addr, input int data);
    gpio_in = {16'd0, addr[7:0], data[7:0]};
    repeat (2) tick();
    gpio_in[31] = 1'b1;
    repeat (4) tick();
    gpio_in[31] = 1'b0;
    repeat (4) tick();
  endtask

  task automatic set_cfg(input int dly, input int len);
    wr(BASE + 0, dly & 255);
    wr(BASE + 1, (dly >> 8) & 255);
    wr(BASE + 2, len & 255);
    wr(BASE + 3, (len >> 8) & 255);
  endtask

  // mode 0: tready always 1; 1: random tready; 2: tready low for 5 cycles mid-capture
  task automatic run_cap(input int dly, input int len, input bit use_fsm,
                         input bit both, input int mode, input bit other_pulse,
                         input string tag);
    int  first, last, obs_first, obs_cnt, mism, drops, busy2, exp_drop, late_busy;
    bit  tr;
    first = dly + 2;
    last  = dly + 2 + len;
    obs_first = -1; obs_cnt = 0; mism = 0; drops = 0; busy2 = -1; late_busy = 0;
    if (use_fsm || both)  fsm_run  = 1'b1;
    if (!use_fsm || both) cpu_trig = 1'b1;
    for (int c = 1; c <= last + 3; c++) begin
      tick();
      if (cap_valid === 1'b1) begin
        if (obs_first < 0) obs_first = c;
        obs_cnt++;
      end
      if (cap_valid !== (c >= first && c <= last)) mism++;
      if (c == 2) busy2 = int'(busy);
      case (mode)
        0:       tr = 1'b1;
        1:       tr = ($urandom_range(0, 3) != 0);
        default: tr = !(c >= first + 10 && c < first + 15);
      endcase
      fifo_tready = tr;
      if (!tr && c >= first && c <= last) drops++;
      if (other_pulse && c == first) begin
        if (use_fsm) cpu_trig = 1'b1;
        else         fsm_run  = 1'b1;
      end
    end
    fifo_tready = 1'b1;
`ifdef ADC_SEQ_DROP_CNT_EN
    exp_drop = (drops > 65535) ? 65535 : drops;
`else
    exp_drop = 0;
`endif
    check({tag, "_first"}, obs_first, first);
    check({tag, "_count"}, obs_cnt, len + 1);
    check({tag, "_window"}, mism, 0);
    check({tag, "_busy_edge1"}, busy2, 1);
    check({tag, "_hold_busy"}, busy, 1);
    check({tag, "_done"}, done, 1);
    check({tag, "_grant"}, grant_fsm, use_fsm);
    check({tag, "_ovf"}, overflow, drops > 0);
    check({tag, "_drop"}, drop_cnt, exp_drop);
    if (use_fsm) fsm_run = 1'b0;
    else         cpu_trig = 1'b0;
    repeat (3) tick();
    check({tag, "_released"}, busy, 0);
    check({tag, "_done_sticky"}, done, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy === 1'b1) late_busy++;
    end
    check({tag, "_no_retrig"}, late_busy, 0);
    cpu_trig = 1'b0;
    fsm_run  = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int busy_cnt;
    int rd, rl;
    bit rs, ro;
    #2 rst = 1'b0;
    repeat (3) tick();
    check("rst_cap_valid", cap_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_grant", grant_fsm, 0);
    check("rst_ovf", overflow, 0);
    check("rst_drop", drop_cnt, 0);
    rst = 1'b1;
    repeat (2) tick();

    // Reset defaults dly=0, len=1023, with a 5-cycle stall mid-capture.
    run_cap(0, 1023, 1'b0, 1'b0, 2, 1'b0, "t4_len1023");

    set_cfg(0, 3);
    run_cap(0, 3, 1'b0, 1'b0, 0, 1'b0, "t1_cpu");

    set_cfg(10, 0);
    run_cap(10, 0, 1'b1, 1'b0, 0, 1'b0, "t2_fsm");

    set_cfg(2, 4);
    run_cap(2, 4, 1'b1, 1'b1, 0, 1'b0, "t3_both");

    // FSM requester disabled: its edge must not start anything.
    wr(BASE + 4, 1);
    fsm_run = 1'b1;
    busy_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy === 1'b1) busy_cnt++;
    end
    check("t5_fsm_disabled", busy_cnt, 0);
    fsm_run = 1'b0;
    repeat (2) tick();
    set_cfg(3, 2);
    run_cap(3, 2, 1'b0, 1'b0, 0, 1'b0, "t5_cpu");
    wr(BASE + 4, 3);

    // Asynchronous reset in the middle of a capture.
    set_cfg(0, 50);
    cpu_trig = 1'b1;
    repeat (10) tick();
    check("t6_pre_cap", cap_valid, 1);
    rst = 1'b0;
    cpu_trig = 1'b0;
    #1;
    check("t6_cap_valid", cap_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    tick();
    rst = 1'b1;
    repeat (2) tick();
    run_cap(0, 1023, 1'b0, 1'b0, 0, 1'b0, "t6_defaults");

    for (int n = 0; n < 8; n++) begin
      rd = $urandom_range(0, 20);
      rl = $urandom_range(0, 40);
      rs = 1'($urandom_range(0, 1));
      ro = 1'($urandom_range(0, 1));
      set_cfg(rd, rl);
      run_cap(rd, rl, rs, 1'b0, 1, ro, $sformatf("rnd%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
